// File: rtl/pipeline_cpu.sv
// pipeline_cpu: 5-stage MIPS-I subset pipeline (IF/ID/EX/MEM/WB) with 32-word IM/DM.
// Macro FORWARDING_EN adds EX/jr operand forwarding; without it RAW hazards stall in ID.

module pc_reg (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] next_pc,
    output logic [31:0] cur_pc
);
    logic [31:0] pc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) pc <= '0;
        else       pc <= next_pc;
    end

    assign cur_pc = pc;
endmodule

module imem (
    input  logic        clock,
    input  logic        load_en,
    input  logic [4:0]  load_addr,
    input  logic [31:0] load_data,
    input  logic [4:0]  addr,
    output logic [31:0] ins
);
    logic [31:0] ins_memory [0:31];

    // Contents survive reset; the load port lets a wrapper fill the array.
    always_ff @(posedge clock) begin
        if (load_en) ins_memory[load_addr] <= load_data;
    end

    assign ins = ins_memory[addr];
endmodule

module regfile (
    input  logic        clock,
    input  logic [4:0]  ra,
    input  logic [4:0]  rb,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rda,
    output logic [31:0] rdb
);
    logic [31:0] gp_registers [0:31];

    always_ff @(posedge clock) begin
        if (we && wa != 5'd0) gp_registers[wa] <= wd;
    end

    // $0 always reads zero; a same-cycle WB write is visible to ID.
    always_comb begin
        rda = gp_registers[ra];
        rdb = gp_registers[rb];
        if (ra == 5'd0)           rda = '0;
        else if (we && wa == ra)  rda = wd;
        if (rb == 5'd0)           rdb = '0;
        else if (we && wa == rb)  rdb = wd;
    end
endmodule

module dmem (
    input  logic        clock,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] wd,
    output logic [31:0] rd
);
    logic [31:0] data_memory [0:31];

    always_ff @(posedge clock) begin
        if (we) data_memory[addr] <= wd;
    end

    assign rd = data_memory[addr];
endmodule

module pipeline_cpu (
    input  logic clock,
    input  logic reset
);
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT,
        ALU_SLL, ALU_SRL, ALU_PASSB, ALU_LINK
    } alu_op_t;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc4;
    } ifid_t;

    typedef struct packed {
        alu_op_t     alu_op;
        logic        use_imm;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        is_beq;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic [4:0]  shamt;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm;
        logic [31:0] pc4;
    } idex_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [4:0]  dest;
        logic [31:0] alu_res;
        logic [31:0] store_val;
    } exmem_t;

    typedef struct packed {
        logic        reg_write;
        logic [4:0]  dest;
        logic [31:0] wb_val;
    } memwb_t;

    function automatic logic hits(input logic we, input logic [4:0] dst, input logic [4:0] src);
        return we && dst != 5'd0 && dst == src;
    endfunction

    ifid_t  ifid;
    idex_t  idex, dec;
    exmem_t exmem;
    memwb_t memwb;

    logic [31:0] cur_pc, pc4, next_pc, ins_f;
    logic [31:0] rs_rf, rt_rf, jr_target, jump_target;
    logic [31:0] fwd_a, fwd_b, alu_b, alu_res, br_target, dm_rd;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic        uses_rs, uses_rt, is_j, is_jr, stall, id_jump, br_taken;

    // ---------------- IF ----------------
    pc_reg PC (.clock(clock), .reset(reset), .next_pc(next_pc), .cur_pc(cur_pc));

    imem IM (.clock(clock), .load_en(1'b0), .load_addr(5'd0), .load_data(32'd0),
             .addr(cur_pc[6:2]), .ins(ins_f));

    assign pc4 = cur_pc + 32'd4;

    // ---------------- ID ----------------
    assign op    = ifid.ins[31:26];
    assign rs    = ifid.ins[25:21];
    assign rt    = ifid.ins[20:16];
    assign rd    = ifid.ins[15:11];
    assign funct = ifid.ins[5:0];

    regfile GPR (.clock(clock), .ra(rs), .rb(rt), .we(memwb.reg_write), .wa(memwb.dest),
                 .wd(memwb.wb_val), .rda(rs_rf), .rdb(rt_rf));

    always_comb begin
        dec        = '0;
        dec.rs     = rs;
        dec.rt     = rt;
        dec.shamt  = ifid.ins[10:6];
        dec.rs_val = rs_rf;
        dec.rt_val = rt_rf;
        dec.pc4    = ifid.pc4;
        dec.imm    = {{16{ifid.ins[15]}}, ifid.ins[15:0]};
        dec.alu_op = ALU_ADD;
        uses_rs    = 1'b0;
        uses_rt    = 1'b0;
        is_j       = 1'b0;
        is_jr      = 1'b0;
        case (op)
            6'h00: begin
                dec.dest      = rd;
                dec.reg_write = 1'b1;
                uses_rs       = 1'b1;
                uses_rt       = 1'b1;
                case (funct)
                    6'h20, 6'h21: dec.alu_op = ALU_ADD;
                    6'h22, 6'h23: dec.alu_op = ALU_SUB;
                    6'h24:        dec.alu_op = ALU_AND;
                    6'h25:        dec.alu_op = ALU_OR;
                    6'h2a:        dec.alu_op = ALU_SLT;
                    6'h00: begin dec.alu_op = ALU_SLL; uses_rs = 1'b0; end
                    6'h02: begin dec.alu_op = ALU_SRL; uses_rs = 1'b0; end
                    6'h08: begin is_jr = 1'b1; dec.reg_write = 1'b0; uses_rt = 1'b0; end
                    default: begin dec.reg_write = 1'b0; uses_rs = 1'b0; uses_rt = 1'b0; end
                endcase
            end
            6'h09: begin
                dec.dest = rt; dec.reg_write = 1'b1; dec.use_imm = 1'b1; uses_rs = 1'b1;
            end
            6'h0d: begin
                dec.dest = rt; dec.reg_write = 1'b1; dec.use_imm = 1'b1; uses_rs = 1'b1;
                dec.alu_op = ALU_OR;
                dec.imm    = {16'd0, ifid.ins[15:0]};
            end
            6'h0f: begin
                dec.dest = rt; dec.reg_write = 1'b1; dec.use_imm = 1'b1;
                dec.alu_op = ALU_PASSB;
                dec.imm    = {ifid.ins[15:0], 16'd0};
            end
            6'h23: begin
                dec.dest = rt; dec.reg_write = 1'b1; dec.use_imm = 1'b1; dec.mem_read = 1'b1;
                uses_rs = 1'b1;
            end
            6'h2b: begin
                dec.use_imm = 1'b1; dec.mem_write = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1;
            end
            6'h04: begin
                dec.is_beq = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1;
            end
            6'h02: is_j = 1'b1;
            6'h03: begin
                is_j = 1'b1; dec.reg_write = 1'b1; dec.dest = 5'd31; dec.alu_op = ALU_LINK;
            end
            default: ;
        endcase
    end

`ifdef FORWARDING_EN
    // Only a load in EX (or a jr whose source is still in EX or is a load in MEM) must wait.
    logic load_use, jr_wait;
    assign load_use  = (uses_rs && hits(idex.mem_read, idex.dest, rs)) ||
                       (uses_rt && hits(idex.mem_read, idex.dest, rt));
    assign jr_wait   = is_jr && (hits(idex.reg_write, idex.dest, rs) ||
                                 hits(exmem.mem_read, exmem.dest, rs));
    assign stall     = load_use || jr_wait;
    assign jr_target = hits(exmem.reg_write && !exmem.mem_read, exmem.dest, rs) ?
                       exmem.alu_res : rs_rf;
`else
    // Hold the consumer in ID until its producer reaches WB and the bypass covers it.
    assign stall = (uses_rs && (hits(idex.reg_write, idex.dest, rs) ||
                                hits(exmem.reg_write, exmem.dest, rs))) ||
                   (uses_rt && (hits(idex.reg_write, idex.dest, rt) ||
                                hits(exmem.reg_write, exmem.dest, rt)));
    assign jr_target = rs_rf;
`endif

    assign jump_target = is_jr ? jr_target : {ifid.pc4[31:28], ifid.ins[25:0], 2'b00};
    assign id_jump     = (is_j || is_jr) && !stall;

    // ---------------- EX ----------------
`ifdef FORWARDING_EN
    always_comb begin
        fwd_a = idex.rs_val;
        fwd_b = idex.rt_val;
        if (hits(exmem.reg_write, exmem.dest, idex.rs))      fwd_a = exmem.alu_res;
        else if (hits(memwb.reg_write, memwb.dest, idex.rs)) fwd_a = memwb.wb_val;
        if (hits(exmem.reg_write, exmem.dest, idex.rt))      fwd_b = exmem.alu_res;
        else if (hits(memwb.reg_write, memwb.dest, idex.rt)) fwd_b = memwb.wb_val;
    end
`else
    assign fwd_a = idex.rs_val;
    assign fwd_b = idex.rt_val;
`endif

    assign alu_b = idex.use_imm ? idex.imm : fwd_b;

    always_comb begin
        alu_res = '0;
        case (idex.alu_op)
            ALU_ADD:   alu_res = fwd_a + alu_b;
            ALU_SUB:   alu_res = fwd_a - alu_b;
            ALU_AND:   alu_res = fwd_a & alu_b;
            ALU_OR:    alu_res = fwd_a | alu_b;
            ALU_SLT:   alu_res = {31'd0, $signed(fwd_a) < $signed(alu_b)};
            ALU_SLL:   alu_res = fwd_b << idex.shamt;
            ALU_SRL:   alu_res = fwd_b >> idex.shamt;
            ALU_PASSB: alu_res = alu_b;
            ALU_LINK:  alu_res = idex.pc4;
            default:   alu_res = '0;
        endcase
    end

    assign br_taken  = idex.is_beq && (fwd_a == fwd_b);
    assign br_target = idex.pc4 + {idex.imm[29:0], 2'b00};

    // ---------------- MEM ----------------
    dmem DM (.clock(clock), .we(exmem.mem_write), .addr(exmem.alu_res[6:2]),
             .wd(exmem.store_val), .rd(dm_rd));

    // A taken branch outranks both a stall and an ID jump (they belong to younger instructions).
    always_comb begin
        if (br_taken)     next_pc = br_target;
        else if (stall)   next_pc = cur_pc;
        else if (id_jump) next_pc = jump_target;
        else              next_pc = pc4;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ifid  <= '0;
            idex  <= '0;
            exmem <= '0;
            memwb <= '0;
        end else begin
            if (br_taken || id_jump) ifid <= '0;
            else if (!stall) begin
                ifid.ins <= ins_f;
                ifid.pc4 <= pc4;
            end
            idex <= (br_taken || stall) ? '0 : dec;

            exmem.reg_write <= idex.reg_write;
            exmem.mem_read  <= idex.mem_read;
            exmem.mem_write <= idex.mem_write;
            exmem.dest      <= idex.dest;
            exmem.alu_res   <= alu_res;
            exmem.store_val <= fwd_b;

            memwb.reg_write <= exmem.reg_write;
            memwb.dest      <= exmem.dest;
            memwb.wb_val    <= exmem.mem_read ? dm_rd : exmem.alu_res;
        end
    end
endmodule

// File: tb/tb_pipeline_cpu.sv
// tb_pipeline_cpu: directed program table, reset/stall/jal sequences, and random
// straight-line programs compared against an instruction-level reference model.

module tb_pipeline_cpu;
    logic clock = 1'b0;
    logic reset = 1'b0;

    pipeline_cpu dut (.clock(clock), .reset(reset));

    always #5 clock = ~clock;

`ifdef FORWARDING_EN
    localparam int EXP_STALLS = 1;
`else
    localparam int EXP_STALLS = 2;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_im  [0:31];
    logic [31:0] m_gpr [0:31];
    logic [31:0] m_dm  [0:31];

    typedef struct {
        bit          is_mem;
        int          idx;
        logic [31:0] exp;
    } chk_t;

    chk_t final_tbl [18];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                          input int sh, input int fn);
        return {6'd0, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
        return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    function automatic logic [31:0] enc_j(input int op, input int tgt);
        return {op[5:0], tgt[25:0]};
    endfunction

    task automatic load_dut();
        for (int i = 0; i < 32; i++) begin
            dut.IM.ins_memory[i]    = m_im[i];
            dut.GPR.gp_registers[i] = m_gpr[i];
            dut.DM.data_memory[i]   = m_dm[i];
        end
    endtask

    task automatic spec_preload();
        for (int i = 0; i < 32; i++) begin
            m_gpr[i] = i;
            m_dm[i]  = i + 32'hAA;
        end
    endtask

    task automatic enter_reset();
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clock);
        #1;
    endtask

    // Architectural interpreter: one instruction per step, no pipeline notion.
    task automatic model_run();
        logic [31:0] pc, npc, ins, a, b, simm, res, ea;
        logic [4:0]  dest;
        bit          wr;
        pc = 32'd0;
        for (int step = 0; step < 400; step++) begin
            ins  = m_im[pc[6:2]];
            npc  = pc + 32'd4;
            a    = m_gpr[ins[25:21]];
            b    = m_gpr[ins[20:16]];
            if (ins[25:21] == 5'd0) a = 32'd0;
            if (ins[20:16] == 5'd0) b = 32'd0;
            simm = {{16{ins[15]}}, ins[15:0]};
            ea   = a + simm;
            wr   = 1'b0;
            dest = ins[20:16];
            res  = 32'd0;
            case (ins[31:26])
                6'h00: begin
                    wr = 1'b1; dest = ins[15:11];
                    case (ins[5:0])
                        6'h20, 6'h21: res = a + b;
                        6'h22, 6'h23: res = a - b;
                        6'h24: res = a & b;
                        6'h25: res = a | b;
                        6'h2a: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        6'h00: res = b << ins[10:6];
                        6'h02: res = b >> ins[10:6];
                        6'h08: begin wr = 1'b0; npc = a; end
                        default: wr = 1'b0;
                    endcase
                end
                6'h09: begin wr = 1'b1; res = ea; end
                6'h0d: begin wr = 1'b1; res = a | {16'd0, ins[15:0]}; end
                6'h0f: begin wr = 1'b1; res = {ins[15:0], 16'd0}; end
                6'h23: begin wr = 1'b1; res = m_dm[ea[6:2]]; end
                6'h2b: m_dm[ea[6:2]] = b;
                6'h04: if (a == b) npc = pc + 32'd4 + (simm << 2);
                6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
                6'h03: begin
                    wr = 1'b1; dest = 5'd31; res = pc + 32'd4;
                    npc = {npc[31:28], ins[25:0], 2'b00};
                end
                default: ;
            endcase
            if (wr && dest != 5'd0) m_gpr[dest] = res;
            if (npc == pc) break;
            pc = npc;
        end
    endtask

    function automatic logic [31:0] rand_ins(input int idx);
        int rs, rt, rd, imm;
        rs  = $urandom_range(0, 7);
        rt  = $urandom_range(0, 7);
        rd  = $urandom_range(0, 7);
        imm = $urandom;
        case ($urandom_range(0, 14))
            0:  return enc_r(rs, rt, rd, 0, 'h20);
            1:  return enc_r(rs, rt, rd, 0, 'h21);
            2:  return enc_r(rs, rt, rd, 0, 'h22);
            3:  return enc_r(rs, rt, rd, 0, 'h23);
            4:  return enc_r(rs, rt, rd, 0, 'h24);
            5:  return enc_r(rs, rt, rd, 0, 'h25);
            6:  return enc_r(rs, rt, rd, 0, 'h2a);
            7:  return enc_r(0, rt, rd, $urandom_range(0, 31), 'h00);
            8:  return enc_r(0, rt, rd, $urandom_range(0, 31), 'h02);
            9:  return enc_i('h09, rs, rt, imm);
            10: return enc_i('h0d, rs, rt, imm);
            11: return enc_i('h0f, 0, rt, imm);
            12: return enc_i('h23, rs, rt, imm);
            13: return enc_i('h2b, rs, rt, imm);
            default: return enc_i('h04, rs, rt, $urandom_range(0, 30 - idx));
        endcase
    endfunction

    initial begin
        logic [31:0] prev_pc;
        int          stalls;
        bit          seen_sll;

        // ---------- directed program ----------
        for (int i = 0; i < 32; i++) m_im[i] = 32'd0;
        m_im[0]  = enc_i('h2b, 0, 2, 0);
        m_im[1]  = enc_r(2, 3, 1, 0, 'h20);
        m_im[2]  = enc_r(5, 1, 4, 0, 'h23);
        m_im[3]  = enc_r(1, 9, 7, 0, 'h24);
        m_im[4]  = enc_r(7, 1, 6, 0, 'h25);
        m_im[5]  = enc_i('h09, 7, 10, 100);
        m_im[6]  = enc_i('h0d, 7, 12, 'h5555);
        m_im[7]  = enc_i('h23, 0, 13, 0);
        m_im[8]  = enc_r(13, 10, 15, 0, 'h20);
        m_im[9]  = enc_j('h03, 'h0c0f);
        m_im[10] = enc_i('h2b, 0, 15, 0);
        m_im[11] = enc_i('h2b, 0, 15, 4);
        m_im[12] = enc_i('h09, 0, 8, 'h54);
        m_im[13] = enc_r(0, 8, 9, 4, 'h00);
        m_im[14] = enc_j('h02, 14);
        m_im[15] = enc_i('h0f, 0, 1, 'h9321);
        m_im[16] = enc_i('h0d, 1, 10, 'h55aa);
        m_im[17] = enc_r(0, 10, 11, 7, 'h00);
        m_im[18] = enc_r(31, 0, 0, 0, 'h08);

        final_tbl[0]  = '{0, 1,  32'h9321_0000};
        final_tbl[1]  = '{0, 4,  32'h0000_0000};
        final_tbl[2]  = '{0, 7,  32'h0000_0001};
        final_tbl[3]  = '{0, 6,  32'h0000_0005};
        final_tbl[4]  = '{0, 10, 32'h9321_55AA};
        final_tbl[5]  = '{0, 12, 32'h0000_5555};
        final_tbl[6]  = '{0, 13, 32'h0000_0002};
        final_tbl[7]  = '{0, 15, 32'h0000_0067};
        final_tbl[8]  = '{0, 31, 32'h0000_0028};
        final_tbl[9]  = '{0, 11, 32'h90AA_D500};
        final_tbl[10] = '{0, 8,  32'h0000_0054};
        final_tbl[11] = '{0, 9,  32'h0000_0540};
        final_tbl[12] = '{0, 2,  32'h0000_0002};
        final_tbl[13] = '{0, 3,  32'h0000_0003};
        final_tbl[14] = '{1, 0,  32'h0000_0067};
        final_tbl[15] = '{1, 1,  32'h0000_0067};
        final_tbl[16] = '{1, 2,  32'h0000_00AC};
        final_tbl[17] = '{1, 31, 32'h0000_00C9};

        #2 reset = 1'b1;
        spec_preload();
        load_dut();
        run_cycles(3);
        check("reset pc", dut.PC.pc, 32'd0);
        check("reset keeps gpr5", dut.GPR.gp_registers[5], 32'd5);
        check("reset keeps dm3", dut.DM.data_memory[3], 32'hAD);

        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        check("first fetch pc", dut.PC.pc, 32'd4);
        prev_pc  = dut.PC.pc;
        stalls   = 0;
        seen_sll = 1'b0;
        for (int cyc = 0; cyc < 150; cyc++) begin
            @(posedge clock); #1;
            if (dut.PC.pc == prev_pc && prev_pc == 32'h24) stalls++;
            prev_pc = dut.PC.pc;
            if (!seen_sll && dut.GPR.gp_registers[11] == 32'h90AA_D500) begin
                seen_sll = 1'b1;
                check("no slot after jal dm0", dut.DM.data_memory[0], 32'd2);
                check("no slot after jal dm1", dut.DM.data_memory[1], 32'hAB);
            end
        end
        check("sll result reached", {31'd0, seen_sll}, 32'd1);
        check("load-use stall cycles", stalls, EXP_STALLS);
        for (int i = 0; i < 18; i++) begin
            if (final_tbl[i].is_mem)
                check($sformatf("final dm%0d", final_tbl[i].idx),
                      dut.DM.data_memory[final_tbl[i].idx], final_tbl[i].exp);
            else
                check($sformatf("final gpr%0d", final_tbl[i].idx),
                      dut.GPR.gp_registers[final_tbl[i].idx], final_tbl[i].exp);
        end

        // ---------- reset mid-run aborts in-flight work ----------
        enter_reset();
        spec_preload();
        load_dut();
        run_cycles(2);
        @(negedge clock);
        reset = 1'b0;
        run_cycles(3);
        #1 reset = 1'b1;
        #1;
        check("midrun reset pc", dut.PC.pc, 32'd0);
        run_cycles(3);
        check("midrun dm0 untouched", dut.DM.data_memory[0], 32'hAA);
        check("midrun gpr1 untouched", dut.GPR.gp_registers[1], 32'd1);
        check("midrun gpr4 untouched", dut.GPR.gp_registers[4], 32'd4);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        check("restart pc", dut.PC.pc, 32'd4);
        run_cycles(150);
        check("restart gpr15", dut.GPR.gp_registers[15], 32'h67);
        check("restart gpr9", dut.GPR.gp_registers[9], 32'h540);
        check("restart dm1", dut.DM.data_memory[1], 32'h67);

        // ---------- random programs vs reference model ----------
        for (int p = 0; p < 8; p++) begin
            enter_reset();
            for (int i = 0; i < 31; i++) m_im[i] = rand_ins(i);
            m_im[31] = enc_j('h02, 31);
            for (int i = 0; i < 32; i++) begin
                m_gpr[i] = (i % 2 == 0) ? $urandom_range(0, 3) : $urandom;
                m_dm[i]  = $urandom;
            end
            load_dut();
            model_run();
            run_cycles(2);
            @(negedge clock);
            reset = 1'b0;
            run_cycles(260);
            for (int i = 1; i < 32; i++)
                check($sformatf("rand%0d gpr%0d", p, i), dut.GPR.gp_registers[i], m_gpr[i]);
            for (int i = 0; i < 32; i++)
                check($sformatf("rand%0d dm%0d", p, i), dut.DM.data_memory[i], m_dm[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
